election_controller: RTL

- Parametrised successor to the fixed 64-voter/4-candidate avatar selection block.
- Runs a timed election: registration phase, voting phase, then a sequential tally that scans one candidate per cycle and reports winner, winner vote count and tie.
- Adds asynchronous reset, a request-valid qualifier, invalid-request detection, a tie flag, a tally-done flag and a per-candidate vote readout port.
- Sits behind the user-request front end; results feed the display/report logic.

---
 rtl/election_pkg.sv | 30 +++
 rtl/election_tally.sv | 73 +++++++
 rtl/election_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/election_pkg.sv
// Shared types and helpers for the election controller and its tally scanner.
package election_pkg;

    typedef enum logic [1:0] {
        PH_REG   = 2'd0,
        PH_VOTE  = 2'd1,
        PH_TALLY = 2'd2,
        PH_DONE  = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_UNREG = 2'd0,
        ST_REG   = 2'd1,
        ST_VOTED = 2'd2
    } voter_status_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SCAN = 2'd1,
        T_DONE = 2'd2
    } tally_state_e;

    localparam logic REQ_REGISTER = 1'b0;
    localparam logic REQ_VOTE     = 1'b1;

    function automatic int max1(int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/election_tally.sv
// Sequential max/tie scanner: examines one candidate count per cycle after start.
module election_tally
    import election_pkg::*;
#(
    parameter int NUM_CANDIDATES = 4,
    parameter int NW = 7,
    localparam int CW = max1($clog2(NUM_CANDIDATES))
)(
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         start,
    input  logic [NUM_CANDIDATES*NW-1:0] counts,
    output logic [1:0]                   state,
    output logic [CW-1:0]                winner,
    output logic [NW-1:0]                votes,
    output logic                         tie
);

    localparam logic [CW-1:0] LAST = CW'(NUM_CANDIDATES - 1);

    tally_state_e  st, st_n;
    logic [CW-1:0] idx, idx_n, best_idx, best_idx_n;
    logic [NW-1:0] best, best_n, cur;
    logic          tie_r, tie_n, scanning;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st       <= T_IDLE;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            tie_r    <= 1'b0;
        end else begin
            st       <= st_n;
            idx      <= idx_n;
            best     <= best_n;
            best_idx <= best_idx_n;
            tie_r    <= tie_n;
        end
    end

    // The start cycle already scans candidate 0, so the result is ready NUM_CANDIDATES cycles later.
    always_comb begin
        st_n       = st;
        idx_n      = idx;
        best_n     = best;
        best_idx_n = best_idx;
        tie_n      = tie_r;
        cur        = counts[int'(idx)*NW +: NW];
        scanning   = ((st == T_IDLE) && start) || (st == T_SCAN);
        if (scanning) begin
            if (cur > best) begin
                best_n     = cur;
                best_idx_n = idx;
                tie_n      = 1'b0;
            end else if ((cur == best) && (best != '0)) begin
                tie_n = 1'b1;
            end
            if (idx == LAST) begin
                st_n = T_DONE;
            end else begin
                st_n  = T_SCAN;
                idx_n = idx + 1'b1;
            end
        end
    end

    assign state  = st;
    assign winner = (st == T_DONE) ? best_idx : '0;
    assign votes  = (st == T_DONE) ? best : '0;
    assign tie    = (st == T_DONE) ? tie_r : 1'b0;

endmodule

// File: rtl/election_controller.sv
// Timed election: registration, voting, then a sequential tally of candidate counts.
module election_controller
    import election_pkg::*;
#(
    parameter int NUM_VOTERS     = 64,
    parameter int BOX_SIZE       = 16,
    parameter int NUM_CANDIDATES = 4,
    parameter int REG_CYCLES     = 100,
    parameter int VOTE_CYCLES    = 100,
    localparam int VW = $clog2(NUM_VOTERS),
    localparam int CW = max1($clog2(NUM_CANDIDATES)),
    localparam int BW = max1($clog2(NUM_VOTERS / BOX_SIZE)),
    localparam int NW = VW + 1
)(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    input  logic          req_type,
    input  logic [VW-1:0] userID,
    input  logic [CW-1:0] candidate,
    input  logic [CW-1:0] rd_cand,
    output logic [NW-1:0] rd_votes,
    output logic [1:0]    phase,
    output logic          resp_valid,
    output logic [BW-1:0] ballotBoxId,
    output logic [NW-1:0] numberOfRegisteredVoters,
    output logic [NW-1:0] numberOfVotesWinner,
    output logic [CW-1:0] WinnerId,
    output logic          Tie,
    output logic          TallyDone,
    output logic          AlreadyRegistered,
    output logic          AlreadyVoted,
    output logic          NotRegistered,
    output logic          VotingHasNotStarted,
    output logic          RegistrationHasEnded,
    output logic          VotingHasEnded,
    output logic          InvalidRequest
);

    localparam int TOTAL = REG_CYCLES + VOTE_CYCLES + NUM_CANDIDATES;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int BSH   = $clog2(BOX_SIZE);

    logic [TW-1:0]                 cnt;
    phase_e                        ph;
    voter_status_e                 status [NUM_VOTERS];
    voter_status_e                 cur_st;
    logic [NW-1:0]                 count [NUM_CANDIDATES];
    logic [NUM_CANDIDATES*NW-1:0]  count_flat;
    logic                          id_ok, cand_ok, rd_ok, is_vote, invalid;
    logic [1:0]                    tally_state;

    always_comb begin
        if (cnt < TW'(REG_CYCLES))                    ph = PH_REG;
        else if (cnt < TW'(REG_CYCLES + VOTE_CYCLES)) ph = PH_VOTE;
        else if (cnt < TW'(TOTAL))                    ph = PH_TALLY;
        else                                          ph = PH_DONE;
    end
    assign phase = ph;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)              cnt <= '0;
        else if (ph != PH_DONE)  cnt <= cnt + 1'b1;
    end

    // Range checks are done at 32 bits so they stay meaningful for non-power-of-two sizes.
    assign id_ok   = 32'(userID) < 32'(NUM_VOTERS);
    assign cand_ok = 32'(candidate) < 32'(NUM_CANDIDATES);
    assign rd_ok   = 32'(rd_cand) < 32'(NUM_CANDIDATES);
    assign is_vote = (req_type == REQ_VOTE);
    assign invalid = !id_ok || (is_vote && (ph == PH_VOTE) && !cand_ok);
    assign cur_st  = status[userID];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            resp_valid               <= 1'b0;
            ballotBoxId              <= '0;
            numberOfRegisteredVoters <= '0;
            AlreadyRegistered        <= 1'b0;
            AlreadyVoted             <= 1'b0;
            NotRegistered            <= 1'b0;
            VotingHasNotStarted      <= 1'b0;
            RegistrationHasEnded     <= 1'b0;
            VotingHasEnded           <= 1'b0;
            InvalidRequest           <= 1'b0;
            for (int i = 0; i < NUM_VOTERS; i++) status[i] <= ST_UNREG;
            for (int k = 0; k < NUM_CANDIDATES; k++) count[k] <= '0;
        end else begin
            resp_valid           <= req_valid;
            AlreadyRegistered    <= 1'b0;
            AlreadyVoted         <= 1'b0;
            NotRegistered        <= 1'b0;
            VotingHasNotStarted  <= 1'b0;
            RegistrationHasEnded <= 1'b0;
            VotingHasEnded       <= 1'b0;
            InvalidRequest       <= 1'b0;
            if (req_valid) begin
                if (id_ok) ballotBoxId <= BW'(userID >> BSH);
                if (invalid) begin
                    InvalidRequest <= 1'b1;
                end else begin
                    case (ph)
                        PH_REG: begin
                            if (is_vote) begin
                                VotingHasNotStarted <= 1'b1;
                            end else if (cur_st != ST_UNREG) begin
                                AlreadyRegistered <= 1'b1;
                            end else begin
                                status[userID]           <= ST_REG;
                                numberOfRegisteredVoters <= numberOfRegisteredVoters + 1'b1;
                            end
                        end
                        PH_VOTE: begin
                            if (!is_vote) begin
                                RegistrationHasEnded <= 1'b1;
                            end else if (cur_st == ST_VOTED) begin
                                AlreadyVoted <= 1'b1;
                            end else if (cur_st == ST_UNREG) begin
                                NotRegistered <= 1'b1;
                            end else begin
                                count[candidate] <= count[candidate] + 1'b1;
                                status[userID]   <= ST_VOTED;
                            end
                        end
                        default: VotingHasEnded <= 1'b1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     rd_votes <= '0;
        else if (rd_ok) rd_votes <= count[rd_cand];
        else            rd_votes <= '0;
    end

    always_comb begin
        count_flat = '0;
        for (int k = 0; k < NUM_CANDIDATES; k++) count_flat[k*NW +: NW] = count[k];
    end

    election_tally #(
        .NUM_CANDIDATES (NUM_CANDIDATES),
        .NW             (NW)
    ) u_tally (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (cnt == TW'(REG_CYCLES + VOTE_CYCLES)),
        .counts (count_flat),
        .state  (tally_state),
        .winner (WinnerId),
        .votes  (numberOfVotesWinner),
        .tie    (Tie)
    );

    assign TallyDone = (tally_state == T_DONE);

endmodule
